// File: rtl/pixel_downscaler_if.sv
// Pixel stream bundle for pixel_downscaler.
// The master drives upscaled beats and the slave returns native pixels.
interface pixel_downscaler_if;
  logic [23:0] pixel_in;
  logic        input_valid;
  logic [23:0] pixel_out;
  logic        output_valid;
  logic        frame_done;

  modport master (
    output pixel_in,
    output input_valid,
    input  pixel_out,
    input  output_valid,
    input  frame_done
  );

  modport slave (
    input  pixel_in,
    input  input_valid,
    output pixel_out,
    output output_valid,
    output frame_done
  );
endinterface

// File: rtl/pixel_downscaler.sv
// Recovers native pixels from an integer-upscaled RGB888 stream.
// DOWNSCALE_AVG_EN selects block averaging; otherwise the top-left sample is used.
module pixel_downscaler #(
  parameter int IMG_W = 384,
  parameter int IMG_H = 216,
  parameter int SCALE = 3
) (
  input logic               clk,
  input logic               rst,
  pixel_downscaler_if.slave bus
);

  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SCW = $clog2(SCALE);

  localparam logic [SCW-1:0] SC_MAX  = SCW'(SCALE - 1);
  localparam logic [CW-1:0]  COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_MAX = RW'(IMG_H - 1);

`ifdef DOWNSCALE_AVG_EN
  localparam int NN = SCALE * SCALE;
  localparam int SW = $clog2(255 * NN + 1);
  localparam int EW = 3 * SW;
`else
  localparam int EW = 24;
`endif

  typedef enum logic {RUN, WRAP} state_t;

  state_t          r_state;
  logic [SCW-1:0]  r_sub_col;
  logic [SCW-1:0]  r_sub_row;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;

  logic [EW-1:0]   r_acc [IMG_W];

  logic [EW-1:0]   r_s1;
  logic            r_s1_v;
  logic            r_s1_f;
  logic [23:0]     r_s2;
  logic            r_s2_v;
  logic            r_s2_f;
  logic [23:0]     r_px;
  logic            r_ov;
  logic            r_fd;

  logic            w_beat;
  logic            w_first;
  logic            w_blk;
  logic            w_frame_end;
  logic            w_wr;
  logic [EW-1:0]   w_new;
  logic [EW-1:0]   w_s1_d;
  logic [23:0]     w_s2_d;

  assign w_beat  = bus.input_valid;
  assign w_first = (r_sub_row == '0) && (r_sub_col == '0);
  assign w_blk   = (r_sub_row == SC_MAX) && (r_sub_col == SC_MAX);
  assign w_frame_end = w_blk && (r_col == COL_MAX) && (r_row == ROW_MAX);

`ifdef DOWNSCALE_AVG_EN
  logic [EW-1:0] w_entry;

  function automatic logic [7:0] avg_ch(input logic [SW-1:0] s);
    logic [SW:0] t;
    t = {1'b0, s} + (SW+1)'(NN / 2);
    return 8'(t / (SW+1)'(NN));
  endfunction

  assign w_entry = r_acc[r_col];
  assign w_wr    = 1'b1;

  // First beat of a block overwrites, so stale sums never leak out.
  always_comb begin
    w_new = '0;
    if (w_first) begin
      w_new = {SW'(bus.pixel_in[23:16]),
               SW'(bus.pixel_in[15:8]),
               SW'(bus.pixel_in[7:0])};
    end else begin
      w_new = {w_entry[3*SW-1:2*SW] + SW'(bus.pixel_in[23:16]),
               w_entry[2*SW-1:SW]   + SW'(bus.pixel_in[15:8]),
               w_entry[SW-1:0]      + SW'(bus.pixel_in[7:0])};
    end
  end

  assign w_s1_d = w_new;
  assign w_s2_d = {avg_ch(r_s1[3*SW-1:2*SW]),
                   avg_ch(r_s1[2*SW-1:SW]),
                   avg_ch(r_s1[SW-1:0])};
`else
  assign w_wr   = w_first;
  assign w_new  = bus.pixel_in;
  assign w_s1_d = r_acc[r_col];
  assign w_s2_d = r_s1;
`endif

  always_ff @(posedge clk) begin
    if (rst && w_beat && w_wr) begin
      r_acc[r_col] <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= RUN;
      r_sub_col <= '0;
      r_sub_row <= '0;
      r_col     <= '0;
      r_row     <= '0;
    end else begin
      unique case (r_state)
        RUN:  if (w_beat && w_frame_end) r_state <= WRAP;
        WRAP: r_state <= RUN;
      endcase
      if (w_beat) begin
        if (r_sub_col != SC_MAX) begin
          r_sub_col <= r_sub_col + SCW'(1);
        end else begin
          r_sub_col <= '0;
          if (r_col != COL_MAX) begin
            r_col <= r_col + CW'(1);
          end else begin
            r_col <= '0;
            if (r_sub_row != SC_MAX) begin
              r_sub_row <= r_sub_row + SCW'(1);
            end else begin
              r_sub_row <= '0;
              r_row <= (r_row == ROW_MAX) ? '0 : r_row + RW'(1);
            end
          end
        end
      end
    end
  end

  // Two register stages after the closing beat: block value, then result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1   <= '0;
      r_s1_v <= 1'b0;
      r_s1_f <= 1'b0;
      r_s2   <= '0;
      r_s2_v <= 1'b0;
      r_s2_f <= 1'b0;
      r_px   <= '0;
      r_ov   <= 1'b0;
      r_fd   <= 1'b0;
    end else begin
      r_s1_v <= w_beat && w_blk;
      r_s1_f <= w_beat && w_frame_end;
      if (w_beat && w_blk) r_s1 <= w_s1_d;
      r_s2_v <= r_s1_v;
      r_s2_f <= r_s1_f;
      if (r_s1_v) r_s2 <= w_s2_d;
      r_ov <= r_s2_v;
      r_fd <= r_s2_f;
      if (r_s2_v) r_px <= r_s2;
    end
  end

  assign bus.pixel_out    = r_px;
  assign bus.output_valid = r_ov;
  assign bus.frame_done   = r_fd;

endmodule

// File: tb/tb_pixel_downscaler.sv
// Self-checking bench for pixel_downscaler (IMG_W=4, IMG_H=2, SCALE=3).
module tb_pixel_downscaler;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int S  = 3;
  localparam int IW = W * S;
  localparam int IH = H * S;
  localparam int NB = IW * IH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   rst_q = 1'b0;
  int   cyc = 0;

  pixel_downscaler_if bus ();

  pixel_downscaler #(
    .IMG_W(W),
    .IMG_H(H),
    .SCALE(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_q <= rst;

  typedef struct {
    string       name;
    logic [23:0] tl;
    logic [23:0] mid;
    logic [23:0] br;
    logic [23:0] exp_avg;
    logic [23:0] exp_tl;
  } vec_t;

  logic [23:0] img [IH][IW];
  logic [23:0] exp_px [$];
  bit          exp_fd [$];
  int          exp_cyc [$];

  int    n_vec = 0;
  int    n_bad = 0;
  int    fd_cnt = 0;
  string cur = "init";
  logic [23:0] last_px = 24'h0;

  always @(negedge clk) begin
    logic [23:0] e_px;
    bit          e_fd;
    int          e_cyc;
    if (!rst_q) begin
      n_vec++;
      if (bus.output_valid !== 1'b0 || bus.frame_done !== 1'b0 ||
          bus.pixel_out !== 24'h0) begin
        n_bad++;
        $display("FAIL %s reset_state: got ov=%b fd=%b px=%06h, want 0 0 000000",
                 cur, bus.output_valid, bus.frame_done, bus.pixel_out);
      end
      last_px = 24'h0;
    end else if (bus.output_valid === 1'b1) begin
      n_vec++;
      if (exp_px.size() == 0 || exp_cyc.size() == 0) begin
        n_bad++;
        $display("FAIL %s unexpected_output: got px=%06h fd=%b at cyc %0d, want none",
                 cur, bus.pixel_out, bus.frame_done, cyc);
      end else begin
        e_px  = exp_px.pop_front();
        e_fd  = exp_fd.pop_front();
        e_cyc = exp_cyc.pop_front();
        if (bus.pixel_out !== e_px || bus.frame_done !== e_fd || cyc != e_cyc) begin
          n_bad++;
          $display("FAIL %s output: got px=%06h fd=%b cyc=%0d, want px=%06h fd=%b cyc=%0d",
                   cur, bus.pixel_out, bus.frame_done, cyc, e_px, e_fd, e_cyc);
        end
      end
      if (bus.frame_done === 1'b1) fd_cnt++;
      last_px = bus.pixel_out;
    end else begin
      n_vec++;
      if (bus.frame_done !== 1'b0 || bus.pixel_out !== last_px) begin
        n_bad++;
        $display("FAIL %s idle_hold: got px=%06h fd=%b, want px=%06h fd=0",
                 cur, bus.pixel_out, bus.frame_done, last_px);
      end
    end
  end

  // Reference: each native pixel from its SxS block of the stored frame.
  function automatic logic [23:0] model_px(int br, int bc);
`ifdef DOWNSCALE_AVG_EN
    int s [3];
    int nn;
    nn = S * S;
    for (int k = 0; k < 3; k++) s[k] = 0;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        s[0] += int'(img[br*S+r][bc*S+c][23:16]);
        s[1] += int'(img[br*S+r][bc*S+c][15:8]);
        s[2] += int'(img[br*S+r][bc*S+c][7:0]);
      end
    for (int k = 0; k < 3; k++) s[k] = (s[k] + nn / 2) / nn;
    return {s[0][7:0], s[1][7:0], s[2][7:0]};
`else
    return img[br*S][bc*S];
`endif
  endfunction

  task automatic push_model();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        exp_px.push_back(model_px(r, c));
        exp_fd.push_back(r == H-1 && c == W-1);
      end
  endtask

  task automatic push_const(input logic [23:0] px);
    for (int i = 0; i < W*H; i++) begin
      exp_px.push_back(px);
      exp_fd.push_back(i == W*H-1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_beat(input logic [23:0] px, input bit last);
    bus.pixel_in    = px;
    bus.input_valid = 1'b1;
    @(posedge clk);
    #1;
    if (last) exp_cyc.push_back(cyc + 2);
    bus.input_valid = 1'b0;
    bus.pixel_in    = 24'($urandom);
  endtask

  // gap: 0 none, 1 line gaps plus random mid-line, 2 random only
  task automatic drive_frame(input int gap, input int limit);
    int n;
    n = 0;
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) begin
        if (n == limit) return;
        if (gap != 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        drive_beat(img[r][c], (r % S == S-1) && (c % S == S-1));
        n++;
        if (gap == 1 && c == IW-1) idle(1);
      end
  endtask

  task automatic fill_blocks(input logic [23:0] tl, input logic [23:0] mid,
                             input logic [23:0] br);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        if (r % S == 0 && c % S == 0) img[r][c] = tl;
        else if (r % S == S-1 && c % S == S-1) img[r][c] = br;
        else img[r][c] = mid;
  endtask

  task automatic fill_index();
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        img[r][c] = 24'h102030 + 24'((r / S) * W + c / S);
  endtask

  task automatic fill_random();
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        img[r][c] = 24'($urandom);
  endtask

  task automatic push_index();
    for (int i = 0; i < W*H; i++) begin
      exp_px.push_back(24'h102030 + 24'(i));
      exp_fd.push_back(i == W*H-1);
    end
  endtask

  vec_t tbl [6];
  int   fd0;

  initial begin
    tbl[0] = '{"round_half_up", 24'h000000, 24'h000000, 24'h050000, 24'h010000, 24'h000000};
    tbl[1] = '{"round_down",    24'h040404, 24'h000000, 24'h000000, 24'h000000, 24'h040404};
    tbl[2] = '{"red_full",      24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000};
    tbl[3] = '{"white_max",     24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    tbl[4] = '{"top_left_only", 24'hABCDEF, 24'h000000, 24'h000000, 24'h13171B, 24'hABCDEF};
    tbl[5] = '{"grey_mid",      24'h000000, 24'h808080, 24'h000000, 24'h646464, 24'h000000};

    bus.pixel_in    = 24'h0;
    bus.input_valid = 1'b0;
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);

    for (int i = 0; i < 6; i++) begin
      cur = tbl[i].name;
      fill_blocks(tbl[i].tl, tbl[i].mid, tbl[i].br);
`ifdef DOWNSCALE_AVG_EN
      push_const(tbl[i].exp_avg);
`else
      push_const(tbl[i].exp_tl);
`endif
      drive_frame((i % 2 == 0) ? 0 : 2, NB);
      idle(4);
    end

    cur = "index_gapless";
    fill_index();
    push_index();
    drive_frame(0, NB);
    idle(4);

    cur = "index_gapped";
    push_index();
    drive_frame(1, NB);
    idle(4);

    cur = "back_to_back";
    fd0 = fd_cnt;
    fill_index();
    push_index();
    drive_frame(0, NB);
    fill_random();
    push_model();
    drive_frame(0, NB);
    idle(4);
    n_vec++;
    if (fd_cnt - fd0 != 2) begin
      n_bad++;
      $display("FAIL back_to_back frame_done_count: got %0d, want 2", fd_cnt - fd0);
    end

    cur = "reset_mid_frame";
    fill_random();
    drive_frame(0, 20);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    fill_random();
    push_model();
    drive_frame(0, NB);
    idle(4);

    for (int k = 0; k < 4; k++) begin
      cur = $sformatf("random_%0d", k);
      fill_random();
      push_model();
      drive_frame(k % 3, NB);
    end
    idle(6);

    cur = "drain";
    n_vec++;
    if (exp_px.size() != 0 || exp_cyc.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending: got %0d px / %0d cyc left, want 0 0",
               exp_px.size(), exp_cyc.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
